// File: rtl/keypad_pkg.sv
// Shared constants, FSM encodings and helpers for the keypad front-end.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    // FSM encodings (2-bit, all four codes in use)
    localparam logic [1:0] SCAN     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESS    = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    // Key code for a (row, column) intersection of the 4x4 matrix.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // True when exactly one bit of an active-low vector is asserted.
    function automatic logic single_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    endfunction

    // Index of the lowest asserted (zero) bit of an active-low vector.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    // Next column in the scan sequence (1110 -> 1101 -> 1011 -> 0111 -> 1110).
    function automatic logic [3:0] rotate_col(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous row inputs; idles at all-ones
// (no key) so reset never looks like a press.
module keypad_sync
    import keypad_pkg::*;
(
    input  logic            ck,
    input  logic            rst_n,
    input  logic [ROWS-1:0] d,
    output logic [ROWS-1:0] q
);

    logic [ROWS-1:0] meta_reg;
    logic [ROWS-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_bit
            // Per-bit two-stage capture of the raw row line
            always_ff @(posedge ck or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, one strobe per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1000
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic            p,
    output logic [3:0]      w,
    output logic            key_down
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    logic [ROWS-1:0]  rs;
    logic [1:0]       state_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DEB_W-1:0] deb_reg;
    logic [COLS-1:0]  col_n_reg;
    logic [1:0]       row_idx_reg;
    logic [1:0]       col_idx_reg;
    logic             p_reg;
    logic [3:0]       w_reg;
    logic             key_down_reg;
    logic [ROWS-1:0]  row_pat;

    keypad_sync u_sync (
        .ck    (ck),
        .rst_n (rst_n),
        .d     (row_n),
        .q     (rs)
    );

    // Active-low row pattern of the key currently being debounced
    assign row_pat = ~(4'b0001 << row_idx_reg);

    // Scan / debounce / press / hold sequencing and all registered outputs
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= SCAN;
            div_reg      <= '0;
            deb_reg      <= '0;
            col_n_reg    <= 4'b1110;
            row_idx_reg  <= 2'd0;
            col_idx_reg  <= 2'd0;
            p_reg        <= 1'b0;
            w_reg        <= 4'h0;
            key_down_reg <= 1'b0;
        end else begin
            p_reg <= 1'b0;
            case (state_reg)
                SCAN: begin
                    if (div_reg == DIV_LAST) begin
                        div_reg <= '0;
                        // Only a single low row is a trustworthy key; ghosts keep scanning
                        if (single_low(rs)) begin
                            row_idx_reg <= low_index(rs);
                            col_idx_reg <= low_index(col_n_reg);
                            deb_reg     <= '0;
                            state_reg   <= DEBOUNCE;
                        end else begin
                            col_n_reg <= rotate_col(col_n_reg);
                        end
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rs == row_pat) begin
                        if (deb_reg == DEB_LAST) begin
                            // Outputs registered on entry so they are visible during PRESS
                            state_reg    <= PRESS;
                            p_reg        <= 1'b1;
                            w_reg        <= key_code(row_idx_reg, col_idx_reg);
                            key_down_reg <= 1'b1;
                        end else begin
                            deb_reg <= deb_reg + DEB_W'(1);
                        end
                    end else begin
                        // Bounce: resume scanning this same column from the start
                        state_reg <= SCAN;
                        div_reg   <= '0;
                    end
                end
                PRESS: begin
                    deb_reg   <= '0;
                    state_reg <= HOLD;
                end
                HOLD: begin
                    if (rs == 4'b1111) begin
                        if (deb_reg == DEB_LAST) begin
                            key_down_reg <= 1'b0;
                            col_n_reg    <= rotate_col(col_n_reg);
                            div_reg      <= '0;
                            deb_reg      <= '0;
                            state_reg    <= SCAN;
                        end else begin
                            deb_reg <= deb_reg + DEB_W'(1);
                        end
                    end else begin
                        deb_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= SCAN;
                    col_n_reg <= 4'b1110;
                    div_reg   <= '0;
                    deb_reg   <= '0;
                end
            endcase
        end
    end

    assign col_n    = col_n_reg;
    assign p        = p_reg;
    assign w        = w_reg;
    assign key_down = key_down_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural matrix keypad model.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic       ck;
    logic       rst_n;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       p;
    logic [3:0] w;
    logic       key_down;

    logic [3:0][3:0] pressed;   // pressed[row][col]
    logic [3:0]      exp_q[$];
    int              vectors;
    int              miscompares;
    logic            prev_p;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .p        (p),
        .w        (w),
        .key_down (key_down)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Matrix model: a row is pulled low when a pressed key sits on a driven column
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            row_n[r] = ~|(pressed[r] & ~col_n);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: every strobe must match the oldest expected key code
    always @(negedge ck) begin
        if (rst_n && p) begin
            chk("p_gap", {31'd0, prev_p}, 32'd0);
            chk("kd_at_p", {31'd0, key_down}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_p", {31'd0, p}, 32'd0);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                chk("w", {28'd0, w}, {28'd0, e});
                $display("press: w=%h expected=%h at %0t", w, e, $time);
            end
        end
        prev_p = p;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic release_all();
        pressed = '0;
        tick(20);
    endtask

    logic [3:0] prev_col;
    int         cyc;
    int         run;

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_p      = 1'b0;
        pressed     = '0;
        rst_n       = 1'b1;

        // 1a: reset mid-run, outputs respond in the same cycle
        #12 rst_n = 1'b0;
        #1;
        chk("rst_col", {28'd0, col_n}, 32'hE);
        chk("rst_p", {31'd0, p}, 32'd0);
        chk("rst_w", {28'd0, w}, 32'd0);
        chk("rst_kd", {31'd0, key_down}, 32'd0);
        tick(2);
        rst_n = 1'b1;

        // 1b: idle scan rotates every SCAN_DIV cycles
        prev_col = col_n;
        cyc = 0;
        while (col_n == prev_col && cyc < 20) begin tick(1); cyc++; end
        for (int k = 0; k < 3; k++) begin
            prev_col = col_n;
            cyc = 0;
            while (col_n == prev_col && cyc < 20) begin tick(1); cyc++; end
            chk("scan_period", cyc, SCAN_DIV);
            chk("scan_order", {28'd0, col_n}, {28'd0, prev_col[2:0], prev_col[3]});
            $display("scan: col_n %b -> %b after %0d cycles", prev_col, col_n, cyc);
        end

        // 2: clean hold of row1/col2, release timing of key_down
        exp_q.push_back(4'h6);
        pressed[1][2] = 1'b1;
        tick(100);
        chk("t2_done", exp_q.size(), 0);
        chk("t2_kd_held", {31'd0, key_down}, 32'd1);
        pressed = '0;
        tick(5);
        chk("t2_kd_release_early", {31'd0, key_down}, 32'd1);
        tick(7);
        chk("t2_kd_release", {31'd0, key_down}, 32'd0);
        tick(20);

        // 3: bouncing press, then stable
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[1][2] = ~pressed[1][2];
            tick(1);
        end
        exp_q.push_back(4'h6);
        pressed[1][2] = 1'b1;
        tick(60);
        chk("t3_done", exp_q.size(), 0);
        release_all();

        // 4: two keys in one column are rejected; single remaining key accepted
        pressed[0][0] = 1'b1;
        pressed[1][0] = 1'b1;
        tick(60);
        chk("t4_no_kd", {31'd0, key_down}, 32'd0);
        exp_q.push_back(4'h4);
        pressed[0][0] = 1'b0;
        tick(60);
        chk("t4_done", exp_q.size(), 0);
        release_all();

        // 5: E then D, w holds between, bouncing release gives no extra strobe
        exp_q.push_back(4'hE);
        pressed[3][0] = 1'b1;
        tick(60);
        chk("t5_e_done", exp_q.size(), 0);
        release_all();
        chk("t5_w_hold", {28'd0, w}, 32'hE);
        chk("t5_kd_off", {31'd0, key_down}, 32'd0);
        exp_q.push_back(4'hD);
        pressed[3][3] = 1'b1;
        tick(60);
        chk("t5_d_done", exp_q.size(), 0);
        for (int i = 0; i < 20; i++) begin
            pressed[3][3] = ~pressed[3][3];
            tick(1);
        end
        chk("t5_kd_bounce", {31'd0, key_down}, 32'd1);
        release_all();
        chk("t5_kd_final", {31'd0, key_down}, 32'd0);
        chk("t5_w_final", {28'd0, w}, 32'hD);

        // 6: reset during debounce suppresses the strobe; key re-detected after
        pressed[2][1] = 1'b1;
        prev_col = col_n;
        run = 1;
        cyc = 0;
        while (run < 5 && cyc < 40) begin
            tick(1);
            cyc++;
            if (col_n == prev_col) run++;
            else begin run = 1; prev_col = col_n; end
        end
        chk("t6_debounce_seen", run, 5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_col", {28'd0, col_n}, 32'hE);
        chk("t6_rst_w", {28'd0, w}, 32'd0);
        chk("t6_rst_kd", {31'd0, key_down}, 32'd0);
        tick(3);
        chk("t6_rst_p", {31'd0, p}, 32'd0);
        exp_q.push_back(4'h8);
        rst_n = 1'b1;
        tick(60);
        chk("t6_done", exp_q.size(), 0);
        chk("t6_kd", {31'd0, key_down}, 32'd1);
        release_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
